// File: rtl/jtlb_pkg.sv
// jtlb_pkg: shared constants, result type and helpers for the joint TLB responder.
package jtlb_pkg;

  // Segment decode of VA[31:29] for the unmapped kernel segments.
  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  // Entry field widths.
  localparam int VPN2W = 19;
  localparam int PFNW  = 20;
  localparam int ASIDW = 8;

  // One translation result as loaded into the output registers.
  typedef struct packed {
    logic [31:0] pa;
    logic        miss;
    logic        ade;
    logic        inval;
    logic        cache;
  } jtlb_res_t;

  // True when VA[63:31] is a proper sign extension (all zeros or all ones).
  function automatic logic va_hi_ok(input logic [63:0] va);
    return (va[63:31] == 33'h0_0000_0000) || (va[63:31] == 33'h1_FFFF_FFFF);
  endfunction

endpackage

// File: rtl/jtlb_if.sv
// jtlb_if: phase enables, fill request/response and CP0 write port of the joint TLB.
interface jtlb_if;
  import jtlb_pkg::*;

  logic             phi1;
  logic             phi2;
  logic [63:0]      pc;
  logic             itlbfill;
  logic             kernel;
  logic [ASIDW-1:0] asid;
  logic             k0cached;
  logic [31:0]      jtlbpa;
  logic             jtlbmiss;
  logic             jtlbade;
  logic             jtlbinval;
  logic             jtlbcache;
  logic             tlbwe;
  logic [4:0]       tlbwidx;
  logic [VPN2W-1:0] tlbwvpn2;
  logic [ASIDW-1:0] tlbwasid;
  logic             tlbwg;
  logic [PFNW-1:0]  tlbwpfn0;
  logic [PFNW-1:0]  tlbwpfn1;
  logic             tlbwc0;
  logic             tlbwc1;
  logic             tlbwv0;
  logic             tlbwv1;

  // Requester / CP0 side: drives requests and writes, observes results.
  modport master (
    output phi1, phi2, pc, itlbfill, kernel, asid, k0cached,
    output tlbwe, tlbwidx, tlbwvpn2, tlbwasid, tlbwg,
    output tlbwpfn0, tlbwpfn1, tlbwc0, tlbwc1, tlbwv0, tlbwv1,
    input  jtlbpa, jtlbmiss, jtlbade, jtlbinval, jtlbcache
  );

  // TLB side.
  modport slave (
    input  phi1, phi2, pc, itlbfill, kernel, asid, k0cached,
    input  tlbwe, tlbwidx, tlbwvpn2, tlbwasid, tlbwg,
    input  tlbwpfn0, tlbwpfn1, tlbwc0, tlbwc1, tlbwv0, tlbwv1,
    output jtlbpa, jtlbmiss, jtlbade, jtlbinval, jtlbcache
  );

endinterface

// File: rtl/jtlb_entry.sv
// jtlb_entry: one even/odd page-pair mapping plus its match and page-select logic.
module jtlb_entry
  import jtlb_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_we,
  input  logic [VPN2W-1:0] i_wvpn2,
  input  logic [ASIDW-1:0] i_wasid,
  input  logic             i_wg,
  input  logic [PFNW-1:0]  i_wpfn0,
  input  logic [PFNW-1:0]  i_wpfn1,
  input  logic             i_wc0,
  input  logic             i_wc1,
  input  logic             i_wv0,
  input  logic             i_wv1,
  input  logic [VPN2W-1:0] i_vpn2,
  input  logic [ASIDW-1:0] i_asid,
  input  logic             i_odd,
  output logic             o_hit,
  output logic             o_sel_valid,
  output logic [PFNW-1:0]  o_sel_pfn,
  output logic             o_sel_cache
);

  logic             r_present;
  logic [VPN2W-1:0] r_vpn2;
  logic [ASIDW-1:0] r_asid;
  logic             r_g;
  logic [PFNW-1:0]  r_pfn0;
  logic [PFNW-1:0]  r_pfn1;
  logic             r_c0;
  logic             r_c1;
  logic             r_v0;
  logic             r_v1;

  // Entry storage: cleared on reset, loaded whole by the CP0 write strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_present <= 1'b0;
      r_vpn2    <= '0;
      r_asid    <= '0;
      r_g       <= 1'b0;
      r_pfn0    <= '0;
      r_pfn1    <= '0;
      r_c0      <= 1'b0;
      r_c1      <= 1'b0;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
    end else if (i_we) begin
      r_present <= 1'b1;
      r_vpn2    <= i_wvpn2;
      r_asid    <= i_wasid;
      r_g       <= i_wg;
      r_pfn0    <= i_wpfn0;
      r_pfn1    <= i_wpfn1;
      r_c0      <= i_wc0;
      r_c1      <= i_wc1;
      r_v0      <= i_wv0;
      r_v1      <= i_wv1;
    end else begin
      r_present <= r_present;
    end
  end

  // Global entries ignore the ASID; VA[12] picks the odd or even half.
  assign o_hit       = r_present && (r_vpn2 == i_vpn2) && (r_g || (r_asid == i_asid));
  assign o_sel_valid = i_odd ? r_v1   : r_v0;
  assign o_sel_pfn   = i_odd ? r_pfn1 : r_pfn0;
  assign o_sel_cache = i_odd ? r_c1   : r_c0;

endmodule

// File: rtl/jtlb.sv
// jtlb: joint TLB responder for ITLB fills. Requests latch on phi2, the
// lookup runs against the array as it stands at the following phi1, and the
// result registers load on that phi1.
module jtlb
  import jtlb_pkg::*;
#(
  parameter int NENT = 32
) (
  input logic     clk,
  input logic     resetn,
  jtlb_if.slave   bus
);

  // Request register.
  logic [63:0]      r_pc;
  logic             r_kernel;
  logic [ASIDW-1:0] r_asid;
  logic             r_k0cached;
  logic             r_pend;

  // Result registers.
  jtlb_res_t        r_res;

  // Per-entry lookup outputs.
  logic [NENT-1:0]  w_hit;
  logic [NENT-1:0]  w_valid;
  logic [NENT-1:0]  w_cache;
  logic [PFNW-1:0]  w_pfn [NENT];

  // Priority-encoded winner.
  logic             w_any;
  logic             w_win_valid;
  logic             w_win_cache;
  logic [PFNW-1:0]  w_win_pfn;

  jtlb_res_t        w_res;

  genvar g;
  generate
    for (g = 0; g < NENT; g++) begin : g_ent
      logic w_we;
      // Indices at or above NENT never compare equal, so those writes drop.
      assign w_we = bus.tlbwe && bus.phi2 && (bus.tlbwidx == 5'(g));
      jtlb_entry u_entry (
        .clk         (clk),
        .resetn      (resetn),
        .i_we        (w_we),
        .i_wvpn2     (bus.tlbwvpn2),
        .i_wasid     (bus.tlbwasid),
        .i_wg        (bus.tlbwg),
        .i_wpfn0     (bus.tlbwpfn0),
        .i_wpfn1     (bus.tlbwpfn1),
        .i_wc0       (bus.tlbwc0),
        .i_wc1       (bus.tlbwc1),
        .i_wv0       (bus.tlbwv0),
        .i_wv1       (bus.tlbwv1),
        .i_vpn2      (r_pc[31:13]),
        .i_asid      (r_asid),
        .i_odd       (r_pc[12]),
        .o_hit       (w_hit[g]),
        .o_sel_valid (w_valid[g]),
        .o_sel_pfn   (w_pfn[g]),
        .o_sel_cache (w_cache[g])
      );
    end
  endgenerate

  // Lowest-index matching entry wins: scan high to low so low indices overwrite.
  always_comb begin
    w_any       = 1'b0;
    w_win_valid = 1'b0;
    w_win_cache = 1'b0;
    w_win_pfn   = '0;
    for (int e = NENT - 1; e >= 0; e--) begin
      w_win_valid = w_hit[e] ? w_valid[e] : w_win_valid;
      w_win_cache = w_hit[e] ? w_cache[e] : w_win_cache;
      w_win_pfn   = w_hit[e] ? w_pfn[e]   : w_win_pfn;
      w_any       = w_any | w_hit[e];
    end
  end

  // Segment decode and translation of the latched request.
  always_comb begin
    w_res = '0;
    if (!va_hi_ok(r_pc)) begin
      w_res.ade = 1'b1;
    end else if (r_pc[31] && !r_kernel) begin
      // kseg0, kseg1 and the mapped kernel segments are kernel-only.
      w_res.ade = 1'b1;
    end else if (r_pc[31:29] == KSEG0) begin
      w_res.pa    = {3'b000, r_pc[28:0]};
      w_res.cache = r_k0cached;
    end else if (r_pc[31:29] == KSEG1) begin
      w_res.pa    = {3'b000, r_pc[28:0]};
      w_res.cache = 1'b0;
    end else if (!w_any) begin
      w_res.miss = 1'b1;
    end else if (!w_win_valid) begin
      w_res.inval = 1'b1;
      w_res.pa    = {w_win_pfn, r_pc[11:0]};
    end else begin
      w_res.pa    = {w_win_pfn, r_pc[11:0]};
      w_res.cache = w_win_cache;
    end
  end

  // Request register: captures the requester context on an accepted phi2 fill.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc       <= 64'h0;
      r_kernel   <= 1'b0;
      r_asid     <= '0;
      r_k0cached <= 1'b0;
    end else if (bus.phi2 && bus.itlbfill) begin
      r_pc       <= bus.pc;
      r_kernel   <= bus.kernel;
      r_asid     <= bus.asid;
      r_k0cached <= bus.k0cached;
    end else begin
      r_pc       <= r_pc;
    end
  end

  // Pending flag: set by an accepted request, consumed by the next phi1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pend <= 1'b0;
    end else if (bus.phi2 && bus.itlbfill) begin
      r_pend <= 1'b1;
    end else if (bus.phi1) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= r_pend;
    end
  end

  // Result registers: load only on the phi1 that completes a pending request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_res <= '0;
    end else if (bus.phi1 && r_pend) begin
      r_res <= w_res;
    end else begin
      r_res <= r_res;
    end
  end

  assign bus.jtlbpa    = r_res.pa;
  assign bus.jtlbmiss  = r_res.miss;
  assign bus.jtlbade   = r_res.ade;
  assign bus.jtlbinval = r_res.inval;
  assign bus.jtlbcache = r_res.cache;

endmodule

// File: tb/tb_jtlb.sv
// tb_jtlb: directed stimulus with a scoreboard queue and a bus monitor.
module tb_jtlb;
  import jtlb_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] pa;
    logic        miss;
    logic        ade;
    logic        inval;
    logic        cache;
    bit          full;   // 0: pa/cache not checked
  } exp_t;

  logic clk;
  logic resetn;
  jtlb_if bus ();

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  jtlb #(.NENT(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (required: finish)");
    $fatal(1, "timeout");
  end

  function automatic void push(input string nm, input logic [31:0] pa,
                               input logic miss, input logic ade,
                               input logic inval, input logic cache,
                               input bit full);
    exp_t e;
    e.name = nm; e.pa = pa; e.miss = miss; e.ade = ade;
    e.inval = inval; e.cache = cache; e.full = full;
    sb.push_back(e);
  endfunction

  // One clk cycle with the given phases; inputs change only at negedge.
  task automatic cyc(input bit p1, input bit p2);
    bus.phi1 = p1;
    bus.phi2 = p2;
    @(negedge clk);
    bus.itlbfill = 1'b0;
    bus.tlbwe    = 1'b0;
  endtask

  task automatic set_req(input logic [63:0] pc, input logic kern,
                         input logic [7:0] asid, input logic k0c);
    bus.pc = pc; bus.kernel = kern; bus.asid = asid; bus.k0cached = k0c;
    bus.itlbfill = 1'b1;
  endtask

  task automatic set_wr(input logic [4:0] idx, input logic [18:0] vpn2,
                        input logic [7:0] asid, input logic gl,
                        input logic [19:0] pfn0, input logic c0, input logic v0,
                        input logic [19:0] pfn1, input logic c1, input logic v1);
    bus.tlbwidx = idx; bus.tlbwvpn2 = vpn2; bus.tlbwasid = asid; bus.tlbwg = gl;
    bus.tlbwpfn0 = pfn0; bus.tlbwc0 = c0; bus.tlbwv0 = v0;
    bus.tlbwpfn1 = pfn1; bus.tlbwc1 = c1; bus.tlbwv1 = v1;
    bus.tlbwe = 1'b1;
  endtask

  task automatic request(input logic [63:0] pc, input logic kern,
                         input logic [7:0] asid, input logic k0c);
    set_req(pc, kern, asid, k0c);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic write(input logic [4:0] idx, input logic [18:0] vpn2,
                       input logic [7:0] asid, input logic gl,
                       input logic [19:0] pfn0, input logic c0, input logic v0,
                       input logic [19:0] pfn1, input logic c1, input logic v1);
    set_wr(idx, vpn2, asid, gl, pfn0, c0, v0, pfn1, c1, v1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
  endtask

  task automatic check(input exp_t e);
    bit ok;
    ok = (bus.jtlbmiss === e.miss) && (bus.jtlbade === e.ade) &&
         (bus.jtlbinval === e.inval);
    if (e.full) ok = ok && (bus.jtlbpa === e.pa) && (bus.jtlbcache === e.cache);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got pa=%h miss=%b ade=%b inval=%b cache=%b, required pa=%h miss=%b ade=%b inval=%b cache=%b (pa/cache checked=%0d)",
               e.name, bus.jtlbpa, bus.jtlbmiss, bus.jtlbade, bus.jtlbinval,
               bus.jtlbcache, e.pa, e.miss, e.ade, e.inval, e.cache, e.full);
    end
  endtask

  // Monitor: watches the bus protocol and compares whenever a result is due.
  initial begin
    bit   mon_pend;
    bit   in_rst;
    bit   trig;
    exp_t e;
    mon_pend = 1'b0;
    in_rst   = 1'b0;
    forever begin
      @(posedge clk);
      trig = 1'b0;
      if (!resetn) begin
        mon_pend = 1'b0;
        if (!in_rst) trig = 1'b1;
        in_rst = 1'b1;
      end else begin
        in_rst = 1'b0;
        if (bus.phi1 && mon_pend) begin
          mon_pend = 1'b0;
          trig     = 1'b1;
        end
        if (bus.phi2 && bus.itlbfill) mon_pend = 1'b1;
      end
      if (trig) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got output event, required none (queue empty)");
        end else begin
          e = sb.pop_front();
          check(e);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    bus.phi1 = 1'b0; bus.phi2 = 1'b0; bus.itlbfill = 1'b0; bus.tlbwe = 1'b0;
    bus.pc = 64'h0; bus.kernel = 1'b0; bus.asid = 8'h00; bus.k0cached = 1'b0;
    set_wr(5'd0, 19'h0, 8'h00, 1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    bus.tlbwe = 1'b0;
    push("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    resetn = 1'b1;
    cyc(1'b1, 1'b0);

    push("empty_miss", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'h0000_0000_0040_1000, 1'b1, 8'h05, 1'b0);
    cyc(1'b1, 1'b0);

    write(5'd3, 19'h00200, 8'h05, 1'b0, 20'h00000, 1'b0, 1'b0, 20'h12345, 1'b1, 1'b1);
    push("idx3_asid5_hit", 32'h1234_5234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    request(64'h0000_0000_0040_1234, 1'b0, 8'h05, 1'b0);
    cyc(1'b1, 1'b0);
    push("idx3_asid6_miss", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'h0000_0000_0040_1234, 1'b0, 8'h06, 1'b0);
    cyc(1'b1, 1'b0);

    push("kseg0_k0c1", 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    request(64'hFFFF_FFFF_8000_1000, 1'b1, 8'h05, 1'b1);
    cyc(1'b1, 1'b0);
    push("kseg0_k0c0", 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'hFFFF_FFFF_8000_1000, 1'b1, 8'h05, 1'b0);
    cyc(1'b1, 1'b0);
    push("kseg0_user_ade", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    request(64'hFFFF_FFFF_8000_1000, 1'b0, 8'h05, 1'b1);
    cyc(1'b1, 1'b0);
    push("kseg1_kernel", 32'h0000_2345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'hFFFF_FFFF_A000_2345, 1'b1, 8'h05, 1'b1);
    cyc(1'b1, 1'b0);
    push("badhi_kernel_ade", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    request(64'h0000_0001_0000_0000, 1'b1, 8'h05, 1'b1);
    cyc(1'b1, 1'b0);
    push("badhi_user_ade", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    request(64'h0000_0001_0000_0000, 1'b0, 8'h05, 1'b1);
    cyc(1'b1, 1'b0);
    push("kseg3_user_ade", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    request(64'hFFFF_FFFF_C000_0000, 1'b0, 8'h05, 1'b1);
    cyc(1'b1, 1'b0);
    push("kseg3_kernel_miss", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'hFFFF_FFFF_C000_0000, 1'b1, 8'h05, 1'b1);
    cyc(1'b1, 1'b0);

    write(5'd7, 19'h00200, 8'h00, 1'b1, 20'hAAAAA, 1'b1, 1'b0, 20'h55555, 1'b0, 1'b1);
    push("idx7_even_inval", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    request(64'h0000_0000_0040_0010, 1'b0, 8'h09, 1'b0);
    cyc(1'b1, 1'b0);
    push("idx7_odd_global", 32'h5555_5ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'h0000_0000_0040_1ABC, 1'b0, 8'h09, 1'b0);
    cyc(1'b1, 1'b0);

    write(5'd2, 19'h00200, 8'h00, 1'b1, 20'h0BEEF, 1'b0, 1'b1, 20'h0CAFE, 1'b1, 1'b1);
    push("idx2_wins_even", 32'h0BEE_F010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'h0000_0000_0040_0010, 1'b0, 8'h09, 1'b0);
    cyc(1'b1, 1'b0);
    push("idx2_wins_odd", 32'h0CAF_E234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    request(64'h0000_0000_0040_1234, 1'b0, 8'h05, 1'b0);
    cyc(1'b1, 1'b0);

    // Write and request in the same phi2: the new pfn must be used.
    push("same_phase_write", 32'h1357_9234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_wr(5'd2, 19'h00200, 8'h00, 1'b1, 20'h0BEEF, 1'b0, 1'b1, 20'h13579, 1'b0, 1'b1);
    request(64'h0000_0000_0040_1234, 1'b0, 8'h05, 1'b0);
    cyc(1'b1, 1'b0);

    // Index beyond the array in a narrower config would drop; here idx 31 is real.
    write(5'd31, 19'h00300, 8'h05, 1'b0, 20'h00000, 1'b0, 1'b0, 20'hFEDCB, 1'b1, 1'b1);
    push("idx31_hit", 32'hFEDC_B008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    request(64'h0000_0000_0060_1008, 1'b0, 8'h05, 1'b0);
    cyc(1'b1, 1'b0);

    // Reset between request and its phi1: result discarded, outputs cleared.
    push("reset_midflight", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_req(64'hFFFF_FFFF_8000_1000, 1'b1, 8'h05, 1'b1);
    cyc(1'b0, 1'b1);
    resetn = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    resetn = 1'b1;
    cyc(1'b1, 1'b0);

    push("after_reset_miss", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    request(64'h0000_0000_0040_1234, 1'b0, 8'h05, 1'b0);
    cyc(1'b1, 1'b0);

    repeat (4) cyc(1'b0, 1'b0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL results_outstanding: got %0d unconsumed, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
